pn_fire_scheduler: RTL and testbench

//  Sequences the token-firing datapath of the generated Petri-net engine. Each cycle the

---
 rtl/pn_fire_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_pn_fire_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pn_fire_scheduler.sv
// -----------------------------------------------------------------------------
// pn_fire_scheduler
//
// Chooses one enabled Petri-net transition per firing and hands it to the token
// datapath over a valid/ready handshake. High-priority transitions always beat
// low-priority ones. Within each class, a round-robin pointer gives the next
// turn to the transition after the last one that fired. A run halts when no
// transition is enabled (deadlock) or when the programmed firing limit is
// reached.
//
// Optional feature macro: PN_FIRE_STATS_EN. It adds the lifetime firing total
// and the index of the last accepted firing.
//
// Parameters
//   NT  number of transitions (2..64)
//   IW  transition index width, >= clog2(NT)
//   CW  firing counter / limit width
//
// Ports
//   clk, rst_n   clock (rising edge); asynchronous active-low reset
//   start        pulse: begin or resume a run (accepted in IDLE and HALT)
//   abort        pulse: return to IDLE from any state; overrides start
//   step_mode    1 = one firing per start, 0 = free-run
//   max_fires    firing limit per run, 0 = unlimited
//   hi_mask      1 = transition belongs to the high-priority class
//   t_en         enabled-transition vector from the datapath
//   fire_valid   fire request to the datapath
//   fire_idx     transition to fire; held stable while fire_valid is high
//   fire_ready   datapath accepts; the markings update on this edge
//   busy         state is SCAN or ISSUE
//   halted       state is HALT
//   deadlock     halt reason: no transition was enabled
//   fire_cnt     firings completed in the current run
//   fire_total   (PN_FIRE_STATS_EN) saturating count of firings since reset
//   last_idx     (PN_FIRE_STATS_EN) index of the most recent accepted firing
// -----------------------------------------------------------------------------
module pn_fire_scheduler #(
  parameter int NT = 34,
  parameter int IW = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          step_mode,
  input  logic [CW-1:0] max_fires,
  input  logic [NT-1:0] hi_mask,
  input  logic [NT-1:0] t_en,
  output logic          fire_valid,
  output logic [IW-1:0] fire_idx,
  input  logic          fire_ready,
  output logic          busy,
  output logic          halted,
  output logic          deadlock,
  output logic [CW-1:0] fire_cnt
`ifdef PN_FIRE_STATS_EN
  ,
  output logic [31:0]   fire_total,
  output logic [IW-1:0] last_idx
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, HALT} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_fire_idx;
  logic          r_fire_hi;     // class of the pending pick; selects which pointer advances
  logic          r_deadlock;
  logic [CW-1:0] r_fire_cnt;
  logic [IW-1:0] r_rr_hi, r_rr_lo;

  logic [IW:0]   w_hi_pick, w_lo_pick;  // {found, index}
  logic          w_hs, w_start_ok, w_limit, w_any;
  logic [CW-1:0] w_cnt_inc;
  logic [IW-1:0] w_ptr_nxt;

  // Returns the first set bit of req at or above ptr, wrapping from NT-1 to 0.
  function automatic logic [IW:0] rr_pick(input logic [NT-1:0] req,
                                          input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NT; i++) begin
      j = int'(ptr) + i;
      if (j >= NT) j = j - NT;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  assign w_hi_pick  = rr_pick(t_en & hi_mask, r_rr_hi);
  assign w_lo_pick  = rr_pick(t_en & ~hi_mask, r_rr_lo);
  assign w_any      = w_hi_pick[IW] | w_lo_pick[IW];

  assign w_hs       = (r_state == ISSUE) && fire_ready;
  assign w_start_ok = ((r_state == IDLE) || (r_state == HALT)) && start && !abort;
  assign w_cnt_inc  = r_fire_cnt + 1'b1;
  assign w_limit    = (max_fires != '0) && (w_cnt_inc == max_fires);
  assign w_ptr_nxt  = (r_fire_idx == IW'(NT - 1)) ? '0 : r_fire_idx + 1'b1;

  // NOTE: w_state_nxt gets a default before the case so that every path assigns it
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (start) w_state_nxt = SCAN;
      SCAN:  w_state_nxt = w_any ? ISSUE : HALT;
      ISSUE: if (fire_ready) begin
               if (w_limit)        w_state_nxt = HALT;
               else if (step_mode) w_state_nxt = IDLE;
               else                w_state_nxt = SCAN;
             end
      HALT:  if (start) w_state_nxt = SCAN;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // NOTE: all state updates use non-blocking assignments, so every register sees the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fire_idx <= '0;
      r_fire_hi  <= 1'b0;
      r_deadlock <= 1'b0;
      r_fire_cnt <= '0;
      r_rr_hi    <= '0;
      r_rr_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_ok) begin
        r_fire_cnt <= '0;
        r_deadlock <= 1'b0;
      end

      if (r_state == SCAN) begin
        if (w_hi_pick[IW]) begin
          r_fire_idx <= w_hi_pick[IW-1:0];
          r_fire_hi  <= 1'b1;
        end else if (w_lo_pick[IW]) begin
          r_fire_idx <= w_lo_pick[IW-1:0];
          r_fire_hi  <= 1'b0;
        end else if (!abort) begin
          r_deadlock <= 1'b1;
        end
      end

      // A handshake completes even when abort arrives on the same edge.
      if (w_hs) begin
        r_fire_cnt <= w_cnt_inc;
        if (r_fire_hi) r_rr_hi <= w_ptr_nxt;
        else           r_rr_lo <= w_ptr_nxt;
      end
    end
  end

`ifdef PN_FIRE_STATS_EN
  logic [31:0]   r_fire_total;
  logic [IW-1:0] r_last_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fire_total <= '0;
      r_last_idx   <= '0;
    end else if (w_hs) begin
      if (r_fire_total != '1) r_fire_total <= r_fire_total + 1'b1;
      r_last_idx <= r_fire_idx;
    end
  end

  assign fire_total = r_fire_total;
  assign last_idx   = r_last_idx;
`endif

  assign fire_valid = (r_state == ISSUE);
  assign fire_idx   = r_fire_idx;
  assign busy       = (r_state == SCAN) || (r_state == ISSUE);
  assign halted     = (r_state == HALT);
  assign deadlock   = r_deadlock;
  assign fire_cnt   = r_fire_cnt;

endmodule

// File: tb/tb_pn_fire_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pn_fire_scheduler: directed checks of pn_fire_scheduler with NT=34.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pn_fire_scheduler;

  localparam int NT = 34;
  localparam int IW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, step_mode, fire_ready;
  logic [CW-1:0] max_fires;
  logic [NT-1:0] hi_mask, t_en;
  logic          fire_valid, busy, halted, deadlock;
  logic [IW-1:0] fire_idx;
  logic [CW-1:0] fire_cnt;
`ifdef PN_FIRE_STATS_EN
  logic [31:0]   fire_total;
  logic [IW-1:0] last_idx;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pn_fire_scheduler #(.NT(NT), .IW(IW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .step_mode  (step_mode),
    .max_fires  (max_fires),
    .hi_mask    (hi_mask),
    .t_en       (t_en),
    .fire_valid (fire_valid),
    .fire_idx   (fire_idx),
    .fire_ready (fire_ready),
    .busy       (busy),
    .halted     (halted),
    .deadlock   (deadlock),
    .fire_cnt   (fire_cnt)
`ifdef PN_FIRE_STATS_EN
    ,
    .fire_total (fire_total),
    .last_idx   (last_idx)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench on the falling edge just after the start edge (state SCAN).
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Waits at most max_wait falling edges for fire_valid and checks the pick.
  // When fire_ready is high, it steps past the handshake edge.
  task automatic expect_fire(input string tag, input int exp_idx, input int max_wait);
    int w = 0;
    while (!fire_valid && w < max_wait) begin
      tick();
      w++;
    end
    check({tag, ".valid"}, fire_valid, 1);
    check({tag, ".idx"}, fire_idx, exp_idx);
    if (fire_ready) tick();
  endtask

  // Runs until HALT; returns how many handshakes were seen (fire_ready held 1).
  task automatic run_to_halt(input string tag, output int n_fires);
    n_fires = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      if (fire_valid && fire_ready) n_fires++;
      tick();
    end
    check({tag, ".halted"}, halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; step_mode = 1'b0; fire_ready = 1'b0;
    max_fires = '0; hi_mask = 34'h0_0000_000F; t_en = '0;

    // Reset state
    tick(); tick();
    check("rst.valid", fire_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.halted", halted, 0);
    check("rst.deadlock", deadlock, 0);
    check("rst.cnt", fire_cnt, 0);
    check("rst.idx", fire_idx, 0);
    rst_n = 1'b1;
    tick();

    // Priority and round-robin, free-run with fire_ready tied high
    t_en = 34'h0_0000_000F; fire_ready = 1'b1;
    pulse_start();
    check("lat.busy", busy, 1);
    check("lat.valid_early", fire_valid, 0);
    expect_fire("rr_hi0", 0, 1);
    expect_fire("rr_hi1", 1, 1);
    expect_fire("rr_hi2", 2, 1);
    expect_fire("rr_hi3", 3, 1);
    expect_fire("rr_hi4", 0, 1);
    t_en = (34'd1 << 4) | (34'd1 << 20);
    expect_fire("rr_lo0", 4, 1);
    expect_fire("rr_lo1", 20, 1);
    expect_fire("rr_lo2", 4, 1);
    expect_fire("rr_lo3", 20, 1);
    check("rr.cnt", fire_cnt, 9);
    do_abort();
    check("rr.abort_busy", busy, 0);

    // Deadlock
    t_en = '0;
    pulse_start();
    check("dl.valid0", fire_valid, 0);
    tick();
    check("dl.halted", halted, 1);
    check("dl.deadlock", deadlock, 1);
    check("dl.cnt", fire_cnt, 0);
    check("dl.valid1", fire_valid, 0);
    tick();
    check("dl.stay", halted, 1);
    t_en = 34'd1 << 5;
    pulse_start();
    check("dl.clear", deadlock, 0);
    check("dl.resume", halted, 0);
    expect_fire("dl.fire", 5, 1);
    do_abort();

    // Firing limit
    max_fires = 16'd3; t_en = 34'd1;
    pulse_start();
    run_to_halt("lim", n);
    check("lim.n", n, 3);
    check("lim.deadlock", deadlock, 0);
    check("lim.cnt", fire_cnt, 3);
    fire_ready = 1'b0;
    pulse_start();
    check("lim.restart_cnt", fire_cnt, 0);
    expect_fire("lim.hold", 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lim.hold_valid", fire_valid, 1);
      check("lim.hold_idx", fire_idx, 0);
      check("lim.hold_cnt", fire_cnt, 0);
    end
    fire_ready = 1'b1;
    tick();
    check("lim.release_cnt", fire_cnt, 1);
    do_abort();

    // Step mode
    max_fires = '0; step_mode = 1'b1; t_en = 34'd1 << 1;
    pulse_start();
    expect_fire("step0", 1, 1);
    check("step0.busy", busy, 0);
    check("step0.halted", halted, 0);
    check("step0.cnt", fire_cnt, 1);
    tick();
    check("step0.idle_hold", busy, 0);
    pulse_start();
    expect_fire("step1", 1, 1);
    check("step1.busy", busy, 0);
    check("step1.cnt", fire_cnt, 1);

    // abort together with fire_ready: handshake is counted, then IDLE
    step_mode = 1'b0; fire_ready = 1'b0; t_en = 34'd1 << 2;
    pulse_start();
    expect_fire("abrt", 2, 1);
    fire_ready = 1'b1; abort = 1'b1;
    tick();
    fire_ready = 1'b0; abort = 1'b0;
    check("abrt.cnt", fire_cnt, 1);
    check("abrt.valid", fire_valid, 0);
    check("abrt.busy", busy, 0);

    // abort beats start in HALT
    t_en = '0;
    pulse_start();
    tick();
    check("ab_st.halted", halted, 1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("ab_st.halted_after", halted, 0);
    check("ab_st.busy", busy, 0);

    // Two limited runs after a fresh reset: 4 firings of 7, then 6 of 9
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fire_ready = 1'b1; max_fires = 16'd4; t_en = 34'd1 << 7;
    tick();
    pulse_start();
    run_to_halt("run1", n);
    check("run1.n", n, 4);
    check("run1.cnt", fire_cnt, 4);
    max_fires = 16'd6; t_en = 34'd1 << 9;
    pulse_start();
    run_to_halt("run2", n);
    check("run2.n", n, 6);
    check("run2.cnt", fire_cnt, 6);
`ifdef PN_FIRE_STATS_EN
    check("stats.total", fire_total, 10);
    check("stats.last", last_idx, 9);
`endif

    // Reset asserted mid-ISSUE
    max_fires = '0; t_en = 34'd1;
    pulse_start();
    expect_fire("mid0", 0, 1);
    expect_fire("mid1", 0, 1);
    fire_ready = 1'b0;
    expect_fire("mid2", 0, 1);
    check("mid.cnt_before", fire_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid.valid", fire_valid, 0);
    check("mid.busy", busy, 0);
    check("mid.halted", halted, 0);
    check("mid.cnt", fire_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid.idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
